// File: rtl/muldiv_seq_if.sv
// Decoder <-> muldiv_seq handshake bundle. Signal names carry the sequencer's own
// direction suffixes so both sides refer to the same port names.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             flush_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] result_o;
    logic             done_o;
    logic             busy_o;
    logic             stall_o;
    logic             illegal_o;

    modport master (
        output start_i, flush_i, op_i, a_i, b_i,
        input  result_o, done_o, busy_o, stall_o, illegal_o
    );

    modport slave (
        input  start_i, flush_i, op_i, a_i, b_i,
        output result_o, done_o, busy_o, stall_o, illegal_o
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative radix-2 RISC-V M-extension multiply/divide sequencer (one bit per cycle).
// Define MULDIV_DIV_EN to build the restoring divider; otherwise divide ops return illegal_o.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   b_mag_q, b_mag_d, result_q, result_d;
    logic               neg_q, neg_d, hi_sel_q, hi_sel_d;
`ifdef MULDIV_DIV_EN
    logic               div_q, div_d, rem_q, rem_d;
`else
    logic               illegal_q, illegal_d;
`endif

    logic               op_div, a_signed, b_signed, a_neg, b_neg, accept;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   hi_nx, lo_nx, mul_word, final_word;
    logic [2*WIDTH-1:0] prod_nx, prod_c;

    // Operand decode: signed ops work on magnitudes and fix the sign on the way out.
    assign op_div   = bus.op_i[2];
    assign a_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b010) ||
                      (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
    assign b_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
    assign a_neg    = a_signed & bus.a_i[WIDTH-1];
    assign b_neg    = b_signed & bus.b_i[WIDTH-1];
    assign a_mag    = a_neg ? -bus.a_i : bus.a_i;
    assign b_mag    = b_neg ? -bus.b_i : bus.b_i;
    assign accept   = bus.start_i & ~bus.flush_i & ((state_q == S_IDLE) || (state_q == S_DONE));

    // Multiply step: {hi,lo} holds partial product above the unconsumed multiplier bits.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_mag_q} : '0);

`ifdef MULDIV_DIV_EN
    logic             div_ge, div_zero, div_ovf;
    logic [WIDTH:0]   div_shift, div_diff;
    logic [WIDTH-1:0] div_word;

    // Restoring step: hi is the partial remainder, lo shifts dividend out and quotient in.
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_mag_q};
    assign div_ge    = ~div_diff[WIDTH];
    assign hi_nx     = div_q ? (div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0])
                             : mul_sum[WIDTH:1];
    assign lo_nx     = div_q ? {lo_q[WIDTH-2:0], div_ge} : {mul_sum[0], lo_q[WIDTH-1:1]};
    assign div_zero  = (bus.b_i == '0);
    assign div_ovf   = op_div & b_signed & (bus.a_i == {1'b1, {(WIDTH-1){1'b0}}}) &
                       (bus.b_i == '1);
`else
    assign hi_nx     = mul_sum[WIDTH:1];
    assign lo_nx     = {mul_sum[0], lo_q[WIDTH-1:1]};
`endif

    assign prod_nx  = {hi_nx, lo_nx};
    assign prod_c   = neg_q ? -prod_nx : prod_nx;
    assign mul_word = hi_sel_q ? prod_c[2*WIDTH-1:WIDTH] : prod_c[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    assign div_word   = rem_q ? hi_nx : lo_nx;
    assign final_word = div_q ? (neg_q ? -div_word : div_word) : mul_word;
`else
    assign final_word = mul_word;
`endif

    always_comb begin
        // NOTE: every _d gets a default first, so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_mag_d  = b_mag_q;
        neg_d    = neg_q;
        hi_sel_d = hi_sel_q;
        result_d = result_q;
`ifdef MULDIV_DIV_EN
        div_d    = div_q;
        rem_d    = rem_q;
`else
        illegal_d = 1'b0;
`endif
        case (state_q)
            S_RUN: begin
                hi_d  = hi_nx;
                lo_d  = lo_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    result_d = final_word;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = state_q;
        endcase

        if (accept) begin
            state_d  = S_RUN;
            cnt_d    = '0;
            hi_d     = '0;
            lo_d     = a_mag;
            b_mag_d  = b_mag;
            neg_d    = (op_div & bus.op_i[1]) ? a_neg : (a_neg ^ b_neg);
            hi_sel_d = bus.op_i[1] | bus.op_i[0];
`ifdef MULDIV_DIV_EN
            div_d    = op_div;
            rem_d    = bus.op_i[1];
            if (op_div && div_zero) begin
                state_d  = S_DONE;
                result_d = bus.op_i[1] ? bus.a_i : '1;
            end else if (div_ovf) begin
                state_d  = S_DONE;
                result_d = bus.op_i[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
            end
`else
            if (op_div) begin
                state_d   = S_DONE;
                result_d  = '0;
                illegal_d = 1'b1;
            end
`endif
        end

        // An aborted operation leaves the previous result visible.
        if (bus.flush_i) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_mag_q   <= '0;
            neg_q     <= 1'b0;
            hi_sel_q  <= 1'b0;
            result_q  <= '0;
`ifdef MULDIV_DIV_EN
            div_q     <= 1'b0;
            rem_q     <= 1'b0;
`else
            illegal_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking only, so every register samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_mag_q   <= b_mag_d;
            neg_q     <= neg_d;
            hi_sel_q  <= hi_sel_d;
            result_q  <= result_d;
`ifdef MULDIV_DIV_EN
            div_q     <= div_d;
            rem_q     <= rem_d;
`else
            illegal_q <= illegal_d;
`endif
        end
    end

    assign bus.result_o = result_q;
    assign bus.done_o   = (state_q == S_DONE);
    assign bus.busy_o   = (state_q == S_RUN);
    assign bus.stall_o  = accept | (state_q == S_RUN);
`ifdef MULDIV_DIV_EN
    assign bus.illegal_o = 1'b0;
`else
    assign bus.illegal_o = illegal_q;
`endif
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq; divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_seq;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [31:0] last_res;

    muldiv_seq_if #(.WIDTH(32)) bus_if ();

    muldiv_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Move to the next cycle, 1 time unit after the falling edge.
    task automatic idle();
        @(negedge clk);
        #1;
    endtask

    // Cycle 0 is the current cycle: start is driven now and sampled on the next rising edge.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_res, input logic exp_ill);
        int          done_cyc;
        int          run_bad;
        logic        done_stall;
        logic [31:0] res;
        logic        ill;
        bus_if.op_i    = op;
        bus_if.a_i     = a;
        bus_if.b_i     = b;
        bus_if.start_i = 1'b1;
        #1;
        check($sformatf("%s stall_c0", tag), 64'(bus_if.stall_o), 64'd1);
        done_cyc   = -1;
        run_bad    = 0;
        done_stall = 1'bx;
        res        = 'x;
        ill        = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) bus_if.start_i = 1'b0;
            #1;
            if (bus_if.done_o === 1'b1) begin
                done_cyc   = c;
                done_stall = bus_if.stall_o | bus_if.busy_o;
                res        = bus_if.result_o;
                ill        = bus_if.illegal_o;
                break;
            end
            if ({bus_if.busy_o, bus_if.stall_o} !== 2'b11) run_bad++;
        end
        check($sformatf("%s done_cycle", tag), 64'(done_cyc), 64'(exp_lat));
        check($sformatf("%s result", tag), 64'(res), 64'(exp_res));
        check($sformatf("%s illegal", tag), 64'(ill), 64'(exp_ill));
        check($sformatf("%s stall_in_done", tag), 64'(done_stall), 64'd0);
        check($sformatf("%s busy_stall_in_run", tag), 64'(run_bad), 64'd0);
        last_res = exp_res;
    endtask

    task automatic run_div(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int lat, input logic [31:0] res);
        run_op(tag, op, a, b, DIV_EN ? lat : 1, DIV_EN ? res : 32'h0, ~DIV_EN);
    endtask

    initial begin
        int   saw;
        n_checks = 0;
        n_fail   = 0;
        last_res = '0;
        rst_n            = 1'b0;
        bus_if.start_i   = 1'b0;
        bus_if.flush_i   = 1'b0;
        bus_if.op_i      = 3'b000;
        bus_if.a_i       = '0;
        bus_if.b_i       = '0;

        // Reset state
        #2;
        check("in_reset outputs", 64'({bus_if.result_o, bus_if.done_o, bus_if.busy_o,
                                       bus_if.stall_o, bus_if.illegal_o}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        check("after_reset outputs", 64'({bus_if.result_o, bus_if.done_o, bus_if.busy_o,
                                          bus_if.stall_o, bus_if.illegal_o}), 64'd0);

        // Multiply, MULHU issued back-to-back in MUL's DONE cycle
        run_op("MUL", 3'b000, 32'd7, 32'hFFFF_FFFA, 33, 32'hFFFF_FFD6, 1'b0);
        run_op("MULHU b2b", 3'b011, 32'd7, 32'hFFFF_FFFA, 33, 32'h0000_0006, 1'b0);
        idle();
        run_op("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 1'b0);
        idle();
        run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFF, 1'b0);
        idle();

        // Divide
        run_div("DIV", 3'b100, 32'hFFFF_FFEC, 32'd3, 33, 32'hFFFF_FFFA);
        idle();
        run_div("REM", 3'b110, 32'hFFFF_FFEC, 32'd3, 33, 32'hFFFF_FFFE);
        idle();
        run_div("DIVU", 3'b101, 32'd100, 32'd7, 33, 32'd14);
        idle();
        run_div("REMU", 3'b111, 32'd100, 32'd7, 33, 32'd2);
        idle();

        // Divide fast paths
        run_div("DIVU by0", 3'b101, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        idle();
        run_div("REM by0", 3'b110, 32'd5, 32'd0, 1, 32'd5);
        idle();
        run_div("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
        idle();
        run_div("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        idle();

        // Flush in cycle 10 of a MUL
        saw = 0;
        bus_if.op_i    = 3'b000;
        bus_if.a_i     = 32'd7;
        bus_if.b_i     = 32'd3;
        bus_if.start_i = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1)  bus_if.start_i = 1'b0;
            if (c == 10) bus_if.flush_i = 1'b1;
            if (c == 11) bus_if.flush_i = 1'b0;
            #1;
            if (c == 10) check("flush busy_c10", 64'(bus_if.busy_o), 64'd1);
            if (c == 11) check("flush idle_c11", 64'({bus_if.busy_o, bus_if.stall_o}), 64'd0);
            if (bus_if.done_o !== 1'b0) saw++;
        end
        check("flush no_done", 64'(saw), 64'd0);
        check("flush result_kept", 64'(bus_if.result_o), 64'(last_res));

        // start and flush in the same cycle: no accept
        saw = 0;
        bus_if.start_i = 1'b1;
        bus_if.flush_i = 1'b1;
        #1;
        check("start_flush stall", 64'(bus_if.stall_o), 64'd0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus_if.start_i = 1'b0;
            bus_if.flush_i = 1'b0;
            #1;
            if ({bus_if.busy_o, bus_if.done_o} !== 2'b00) saw++;
        end
        check("start_flush no_accept", 64'(saw), 64'd0);

        // Give result_o a nonzero value, then reset mid-operation in cycle 5
        run_op("MUL 5x5", 3'b000, 32'd5, 32'd5, 33, 32'd25, 1'b0);
        idle();
        bus_if.op_i    = 3'b000;
        bus_if.a_i     = 32'd7;
        bus_if.b_i     = 32'd3;
        bus_if.start_i = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) bus_if.start_i = 1'b0;
            #1;
        end
        check("pre_reset busy", 64'(bus_if.busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset outputs", 64'({bus_if.result_o, bus_if.done_o, bus_if.busy_o,
                                          bus_if.stall_o, bus_if.illegal_o}), 64'd0);
        idle();
        rst_n = 1'b1;
        saw = 0;
        for (int c = 1; c <= 40; c++) begin
            idle();
            if ({bus_if.busy_o, bus_if.done_o} !== 2'b00) saw++;
        end
        check("post_reset no_done", 64'(saw), 64'd0);

        // Normal operation after reset
        run_op("MULHU max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 1'b0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
